// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC, runs the instruction fetch handshake and
// computes the next PC on retire. Optional misalign trap enabled by PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [1:0]  control,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        exec_done,
  input  logic        freeze,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
`ifdef PC_MISALIGN_TRAP_EN
    ,ST_TRAP = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        boot_armed_q, boot_armed_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] jalr_sum;
  logic [31:0] next_pc;
  logic        retire;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  assign pc_plus4_w = pc_q + 32'd4;
  assign jalr_sum   = rs1_data + imm;
  assign retire     = (state_q == ST_HOLD) && exec_done && !freeze;

  // JALR wins over taken branch; JALR target has bit 0 cleared.
  always_comb begin
    if (control[0]) begin
      next_pc = jalr_sum & ~32'd1;
    end else if (control[1]) begin
      next_pc = pc_q + imm;
    end else begin
      next_pc = pc_plus4_w;
    end
  end

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= ST_BOOT;
      boot_armed_q <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      boot_armed_q <= boot_armed_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    boot_armed_d = boot_armed_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      ST_BOOT: begin
        // BOOT spans the full cycle after reset release before fetching starts.
        boot_armed_d = 1'b1;
        if (boot_armed_q) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          instr_d = fetch_data;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          instr_d = NOP_INSTR;
`ifdef PC_MISALIGN_TRAP_EN
          pc_d = next_pc;
          if (next_pc[1]) begin
            misalign_d = 1'b1;
            state_d    = ST_TRAP;
          end else begin
            state_d = ST_FETCH;
          end
`else
          pc_d    = next_pc & ~32'd3;
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    fetch_req   = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_HOLD);
    redirect    = retire && (control != 2'b00);
    instr       = instr_q;
    fetch_addr  = pc_q;
    pc          = pc_q;
    pc_plus4    = pc_plus4_w;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_err = misalign_q;
`else
    misalign_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model and per-cycle compare.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [1:0]  control = 2'b00;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic        exec_done = 1'b0;
  logic        freeze = 1'b0;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_data = 32'd0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .nRst(nRst), .control(control), .imm(imm), .rs1_data(rs1_data),
    .exec_done(exec_done), .freeze(freeze), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phases: 0 just out of reset, 1 boot cycle, 2 fetching, 3 holding, 4 trapped.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;
  logic [31:0] m_nxt;

  function automatic logic [31:0] spec_next(input logic [31:0] p, input logic [1:0] c,
                                            input logic [31:0] i, input logic [31:0] r);
    logic [31:0] t;
    if (c[0]) begin
      t = r + i;
      t[0] = 1'b0;
    end else if (c[1]) begin
      t = p + i;
    end else begin
      t = p + 32'd4;
    end
    return t;
  endfunction

  assign m_nxt = spec_next(m_pc, control, imm, rs1_data);

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_phase <= 0;
      m_pc    <= RST_PC;
      m_instr <= NOP;
      m_err   <= 1'b0;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: m_phase <= 2;
        2: if (fetch_ack) begin
             m_instr <= fetch_data;
             m_phase <= 3;
           end
        3: if (exec_done && !freeze) begin
             m_instr <= NOP;
`ifdef PC_MISALIGN_TRAP_EN
             m_pc    <= m_nxt;
             m_err   <= m_err | m_nxt[1];
             m_phase <= m_nxt[1] ? 4 : 2;
`else
             m_pc    <= {m_nxt[31:2], 2'b00};
             m_phase <= 2;
`endif
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("m_fetch_req", {31'd0, fetch_req}, {31'd0, m_phase == 2});
    chk("m_fetch_addr", fetch_addr, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 3});
    chk("m_instr", instr, (m_phase == 3) ? m_instr : NOP);
    chk("m_redirect", {31'd0, redirect},
        {31'd0, (m_phase == 3) && exec_done && !freeze && (control != 2'b00)});
    chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fetch_req && n < 20) begin
      step();
      n++;
    end
    chk("fetch_wait", {31'd0, fetch_req}, 32'd1);
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] data);
    wait_fetch();
    repeat (delay) step();
    fetch_ack  = 1'b1;
    fetch_data = data;
    step();
    fetch_ack = 1'b0;
    chk("fetch_instr", instr, data);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire(input logic [1:0] c, input logic [31:0] i, input logic [31:0] r,
                        input logic [31:0] exp_pc, input logic exp_redir);
    control   = c;
    imm       = i;
    rs1_data  = r;
    exec_done = 1'b1;
    #1;
    chk("retire_redirect", {31'd0, redirect}, {31'd0, exp_redir});
    step();
    exec_done = 1'b0;
    control   = 2'b00;
    chk("retire_pc", pc, exp_pc);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);

    nRst = 1'b1;
    step();
    chk("boot_edge1_req", {31'd0, fetch_req}, 32'd0);
    step();
    chk("boot_edge2_req", {31'd0, fetch_req}, 32'd1);
    chk("boot_edge2_addr", fetch_addr, 32'h0);
    do_fetch(2, 32'h00500093);

    retire(2'b01, 32'h0, 32'h10, 32'h10, 1'b1);
    do_fetch(0, 32'h00108093);
    retire(2'b00, 32'h0, 32'h0, 32'h14, 1'b0);
    chk("seq_req", {31'd0, fetch_req}, 32'd1);
    chk("seq_addr", fetch_addr, 32'h14);

    // exec_done during FETCH must be ignored
    exec_done = 1'b1;
    do_fetch(2, 32'h00210113);
    exec_done = 1'b0;
    chk("fetch_exec_ignored_pc", pc, 32'h14);

    // ack while holding must not disturb the held instruction
    fetch_ack  = 1'b1;
    fetch_data = 32'hDEAD_BEEF;
    step();
    fetch_ack = 1'b0;
    chk("hold_ack_instr", instr, 32'h00210113);

    retire(2'b01, 32'h0, 32'h40, 32'h40, 1'b1);
    do_fetch(0, 32'hFE000EE3);
    retire(2'b10, 32'hFFFF_FFF0, 32'h0, 32'h30, 1'b1);
    do_fetch(1, 32'h000080E7);
    retire(2'b01, 32'h4, 32'h101, 32'h104, 1'b1);
    do_fetch(0, 32'h00000067);
    retire(2'b11, 32'h0, 32'h200, 32'h200, 1'b1);
    do_fetch(0, 32'h00318193);

    control   = 2'b00;
    exec_done = 1'b1;
    freeze    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("freeze_pc", pc, 32'h200);
      chk("freeze_valid", {31'd0, instr_valid}, 32'd1);
    end
    freeze = 1'b0;
    #1;
    chk("unfreeze_redirect", {31'd0, redirect}, 32'd0);
    step();
    exec_done = 1'b0;
    chk("unfreeze_pc", pc, 32'h204);
    chk("unfreeze_valid", {31'd0, instr_valid}, 32'd0);

    do_fetch(0, 32'h00420213);
    retire(2'b01, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    chk("top_pc_plus4", pc_plus4, 32'h0);
    do_fetch(0, 32'h00528293);
    retire(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("wrap_pc_plus4", pc_plus4, 32'h4);

    // async reset in the middle of a fetch
    step();
    chk("midfetch_req", {31'd0, fetch_req}, 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_req", {31'd0, fetch_req}, 32'd0);
    chk("async_pc", pc, 32'h0);
    fetch_ack  = 1'b1;
    fetch_data = 32'h0BAD_C0DE;
    step();
    nRst = 1'b1;
    step();
    fetch_ack = 1'b0;
    chk("late_ack_req", {31'd0, fetch_req}, 32'd0);
    chk("late_ack_instr", instr, 32'h13);
    step();
    chk("reboot_req", {31'd0, fetch_req}, 32'd1);
    chk("reboot_addr", fetch_addr, 32'h0);
    do_fetch(0, 32'h00630313);

    retire(2'b01, 32'h0, 32'h8, 32'h8, 1'b1);
    do_fetch(0, 32'h00738393);
    control   = 2'b10;
    imm       = 32'h2;
    exec_done = 1'b1;
    #1;
    chk("mis_redirect", {31'd0, redirect}, 32'd1);
    step();
    exec_done = 1'b0;
    control   = 2'b00;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'hA);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("trap_req", {31'd0, fetch_req}, 32'd0);
      chk("trap_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
`else
    chk("mis_pc", pc, 32'h8);
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    chk("mis_req", {31'd0, fetch_req}, 32'd1);
    chk("mis_addr", fetch_addr, 32'h8);
    do_fetch(0, 32'h00840413);
    retire(2'b00, 32'h0, 32'h0, 32'hC, 1'b0);
`endif
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
